// File: rtl/vector_unit_mc.sv
// Vector processing unit: LANES x DATA_WIDTH SIMD over a vector register file,
// pipelined tree reductions and strided multi-row SRAM load/store.
module vector_unit_mc #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_VREGS  = 32,
  parameter bit SATURATE   = 1'b1,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [127:0]                cmd,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic                        cmd_done,
  output logic                        cmd_err,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  output logic [LANES*DATA_WIDTH-1:0] sram_wdata,
  input  logic [LANES*DATA_WIDTH-1:0] sram_rdata,
  output logic                        sram_we,
  output logic                        sram_re,
  input  logic                        sram_ready
);
  localparam int DW = DATA_WIDTH;
  localparam int VW = LANES * DW;
  localparam int L2 = $clog2(LANES);
  localparam int RW = DW + L2;
  localparam int W2 = 2 * DW;
  localparam logic [7:0] L2_C = 8'(L2);
  localparam logic signed [W2-1:0] SMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [W2-1:0] SMIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03, OP_MAX = 8'h04;
  localparam logic [7:0] OP_MIN = 8'h05, OP_RELU = 8'h10, OP_SUM = 8'h20, OP_RMAX = 8'h21;
  localparam logic [7:0] OP_LOAD = 8'h30, OP_STORE = 8'h31, OP_BCAST = 8'h32, OP_ZERO = 8'h34;

  typedef enum logic [2:0] {IDLE, EXEC, RED, MEM, DONE} state_t;
  state_t state_q, state_d;

  logic [VW-1:0]          vrf [NUM_VREGS];
  logic signed [RW-1:0]   pipe [LANES];
  logic [7:0]             sub_q, red_cnt;
  logic [4:0]             vs1_q, vs2_q, vd_q, reg_q, nreg;
  logic [15:0]            count_q, stride_q, k_q;
  logic signed [15:0]     imm_q;
  logic                   err_q, last_row;

  logic [7:0]  in_op, in_sub;
  logic [4:0]  in_vs1, in_vs2, in_vd;
  logic [15:0] in_count;
  logic        use1, use2, used, bad_sub, in_err, in_red, in_mem;
  logic        unused_bits;

  assign in_op    = cmd[127:120];
  assign in_sub   = cmd[119:112];
  assign in_vs1   = cmd[111:107];
  assign in_vs2   = cmd[106:102];
  assign in_vd    = cmd[101:97];
  assign in_count = cmd[63:48];
  assign unused_bits = ^{cmd[96], cmd[75:64], cmd[15:0]};

  function automatic logic [DW-1:0] clamp(input logic signed [W2-1:0] v);
    if (SATURATE && v > SMAX) return SMAX[DW-1:0];
    if (SATURATE && v < SMIN) return SMIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic signed [RW-1:0] red_op(input logic is_max,
                                                  input logic signed [RW-1:0] a,
                                                  input logic signed [RW-1:0] b);
    if (is_max) return (a > b) ? a : b;
    return a + b;
  endfunction

  always_comb begin
    use1 = 1'b0; use2 = 1'b0; used = 1'b0; bad_sub = 1'b0; in_red = 1'b0; in_mem = 1'b0;
    case (in_sub)
      OP_ADD, OP_SUB, OP_MUL, OP_MAX, OP_MIN: begin use1 = 1'b1; use2 = 1'b1; used = 1'b1; end
      OP_RELU:          begin use1 = 1'b1; used = 1'b1; end
      OP_SUM, OP_RMAX:  begin use1 = 1'b1; used = 1'b1; in_red = 1'b1; end
      OP_LOAD:          begin used = 1'b1; in_mem = 1'b1; end
      OP_STORE:         begin use1 = 1'b1; in_mem = 1'b1; end
      OP_BCAST, OP_ZERO: used = 1'b1;
      default:          bad_sub = 1'b1;
    endcase
    in_err = (in_op != 8'h02) || bad_sub ||
             (use1 && 32'(in_vs1) >= NUM_VREGS) ||
             (use2 && 32'(in_vs2) >= NUM_VREGS) ||
             (used && 32'(in_vd) >= NUM_VREGS);
  end

  assign last_row = (k_q == count_q - 16'd1);
  assign nreg     = (32'(reg_q) == NUM_VREGS - 1) ? 5'd0 : reg_q + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        if (in_err || (in_mem && in_count == 16'd0)) state_d = DONE;
        else if (in_red)                              state_d = RED;
        else if (in_mem)                              state_d = MEM;
        else                                          state_d = EXEC;
      end
      EXEC:    state_d = DONE;
      RED:     if (red_cnt == L2_C) state_d = DONE;
      MEM:     if (sram_ready && last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_done  = (state_q == DONE);
  assign cmd_err   = (state_q == DONE) && err_q;

  logic [VW-1:0]        src1, src2, ew_res;
  logic signed [DW-1:0] a, b;
  logic signed [W2-1:0] ae, be;
  assign src1 = vrf[vs1_q];
  assign src2 = vrf[vs2_q];

  always_comb begin
    ew_res = '0; a = '0; b = '0; ae = '0; be = '0;
    for (int i = 0; i < LANES; i++) begin
      a  = src1[i*DW +: DW];
      b  = src2[i*DW +: DW];
      ae = W2'(a);
      be = W2'(b);
      case (sub_q)
        OP_ADD:   ew_res[i*DW +: DW] = clamp(ae + be);
        OP_SUB:   ew_res[i*DW +: DW] = clamp(ae - be);
        OP_MUL:   ew_res[i*DW +: DW] = clamp(ae * be);
        OP_MAX:   ew_res[i*DW +: DW] = (a > b) ? a : b;
        OP_MIN:   ew_res[i*DW +: DW] = (a < b) ? a : b;
        OP_RELU:  ew_res[i*DW +: DW] = (a < 0) ? '0 : a;
        OP_BCAST: ew_res[i*DW +: DW] = DW'(imm_q);
        default:  ew_res[i*DW +: DW] = '0;
      endcase
    end
  end

  // Reduction: stage 0 captures sign-extended lanes, each later stage halves the live lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_VREGS; r++) vrf[r] <= '0;
      for (int i = 0; i < LANES; i++) pipe[i] <= '0;
      sub_q <= '0; vs1_q <= '0; vs2_q <= '0; vd_q <= '0; reg_q <= '0;
      count_q <= '0; stride_q <= '0; k_q <= '0; imm_q <= '0; err_q <= 1'b0; red_cnt <= '0;
      sram_addr <= '0; sram_wdata <= '0; sram_we <= 1'b0; sram_re <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          sub_q <= in_sub; vs1_q <= in_vs1; vs2_q <= in_vs2; vd_q <= in_vd;
          count_q <= in_count; stride_q <= cmd[47:32]; imm_q <= cmd[31:16];
          err_q <= in_err; k_q <= '0; red_cnt <= '0;
          reg_q <= (in_sub == OP_LOAD) ? in_vd : in_vs1;
          if (!in_err && in_mem && in_count != 16'd0) begin
            sram_addr <= ADDR_WIDTH'(cmd[95:76]);
            if (in_sub == OP_LOAD) sram_re <= 1'b1;
            else begin
              sram_we    <= 1'b1;
              sram_wdata <= vrf[in_vs1];
            end
          end
        end
        EXEC: vrf[vd_q] <= ew_res;
        RED: begin
          red_cnt <= red_cnt + 8'd1;
          if (red_cnt == 8'd0) begin
            for (int i = 0; i < LANES; i++) pipe[i] <= RW'(signed'(src1[i*DW +: DW]));
          end else if (red_cnt < L2_C) begin
            for (int i = 0; i < LANES/2; i++)
              pipe[i] <= red_op(sub_q == OP_RMAX, pipe[2*i], pipe[2*i+1]);
          end else begin
            vrf[vd_q] <= {{(VW-DW){1'b0}}, clamp(W2'(red_op(sub_q == OP_RMAX, pipe[0], pipe[1])))};
          end
        end
        MEM: if (sram_ready) begin
          if (sram_re) vrf[reg_q] <= sram_rdata;
          k_q <= k_q + 16'd1;
          if (last_row) begin
            sram_re <= 1'b0;
            sram_we <= 1'b0;
          end else begin
            sram_addr <= sram_addr + ADDR_WIDTH'(stride_q);
            reg_q     <= nreg;
            if (sram_we) sram_wdata <= vrf[nreg];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
